// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers and raises a pipeline stall when bypassing cannot cover a RAW hazard.
// Stall is combinational from the ID inputs. Slot state and counters update on each rising edge.
// Backpressure: stall freezes PC and IF/ID and puts a bubble into EX; flush overrides stall.
module hazard_scoreboard #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 id_is_ecall,
    input  logic [4:0]           id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 flush,
    output logic                 stall,
    output logic [31:0]          ex_busy_mask,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] ecall_stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // No WB slot is kept: an instruction in WB is already visible through
    // the register file or the bypass network, so it can never cause a stall.
    slot_t ex_q;
    slot_t mem_q;
    slot_t ex_d;

    logic ex_live;
    logic mem_live;
    logic load_use;
    logic ecall_haz;

    assign ex_live  = ex_q.valid  && ex_q.reg_write  && (ex_q.rd  != 5'd0);
    assign mem_live = mem_q.valid && mem_q.reg_write && (mem_q.rd != 5'd0);

    assign load_use = id_valid && ex_live && ex_q.mem_read &&
                      ((id_use_rs1 && (ex_q.rd == id_rs1)) ||
                       (id_use_rs2 && (ex_q.rd == id_rs2)));

    // ECALL only gets x17 bypassed from EX/MEM, so a load result must first reach WB.
    assign ecall_haz = id_valid && id_is_ecall &&
                       ((ex_live && (ex_q.rd == 5'd17)) ||
                        (mem_live && mem_q.mem_read && (mem_q.rd == 5'd17)));

    assign stall = (load_use || ecall_haz) && !flush;

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    always_comb begin
        ex_busy_mask = '0;
        if (ex_live) begin
            ex_busy_mask[ex_q.rd] = 1'b1;
        end
        if (mem_live) begin
            ex_busy_mask[mem_q.rd] = 1'b1;
        end
        ex_busy_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q              <= '0;
            mem_q             <= '0;
            stall_count       <= '0;
            ecall_stall_count <= '0;
        end else begin
            mem_q <= ex_q;
            ex_q  <= ex_d;
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
            if (stall && ecall_haz && (ecall_stall_count != CNT_MAX)) begin
                ecall_stall_count <= ecall_stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard with 4-bit counters so saturation is reachable.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_is_ecall;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic        stall;
    logic [31:0] ex_busy_mask;
    logic [3:0]  stall_count;
    logic [3:0]  ecall_stall_count;

    int n_total = 0;
    int n_pass  = 0;

    hazard_scoreboard #(.CNT_WIDTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_use_rs1        (id_use_rs1),
        .id_use_rs2        (id_use_rs2),
        .id_is_ecall       (id_is_ecall),
        .id_rd             (id_rd),
        .id_reg_write      (id_reg_write),
        .id_mem_read       (id_mem_read),
        .flush             (flush),
        .stall             (stall),
        .ex_busy_mask      (ex_busy_mask),
        .stall_count       (stall_count),
        .ecall_stall_count (ecall_stall_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic ec,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_is_ecall  = ec;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        flush = 1'b0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_total++;
        if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
        n_total++;
        if (ex_busy_mask !== 32'h0) $display("FAIL reset_mask got=%h exp=0", ex_busy_mask); else n_pass++;
        n_total++;
        if (stall_count !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", stall_count); else n_pass++;
        n_total++;
        if (ecall_stall_count !== 4'd0) $display("FAIL reset_ecnt got=%0d exp=0", ecall_stall_count); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
        n_total++;
        if (stall !== 1'b0) $display("FAIL lu_pre got=%b exp=0", stall); else n_pass++;
        tick();
        drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6,x5,x2
        n_total++;
        if (stall !== 1'b1) $display("FAIL lu_stall got=%b exp=1", stall); else n_pass++;
        n_total++;
        if (ex_busy_mask !== 32'h0000_0020) $display("FAIL lu_mask got=%h exp=00000020", ex_busy_mask); else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b0) $display("FAIL lu_release got=%b exp=0", stall); else n_pass++;
        tick();
        idle();
        n_total++;
        if (stall_count !== 4'd1) $display("FAIL lu_cnt got=%0d exp=1", stall_count); else n_pass++;
        n_total++;
        if (ex_busy_mask !== 32'h0000_0040) $display("FAIL lu_mask2 got=%h exp=00000040", ex_busy_mask); else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0,0(x1)
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6,x0,x0
        n_total++;
        if (stall !== 1'b0) $display("FAIL x0_stall got=%b exp=0", stall); else n_pass++;
        n_total++;
        if (ex_busy_mask !== 32'h0) $display("FAIL x0_mask got=%h exp=0", ex_busy_mask); else n_pass++;
        tick();
        idle();
        n_total++;
        if (stall_count !== 4'd0) $display("FAIL x0_cnt got=%0d exp=0", stall_count); else n_pass++;
    endtask

    task automatic test_ecall_alu();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd17, 1'b1, 1'b0);  // addi x17,x0,10
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);   // ecall
        n_total++;
        if (stall !== 1'b1) $display("FAIL ecalu_stall got=%b exp=1", stall); else n_pass++;
        n_total++;
        if (ex_busy_mask !== 32'h0002_0000) $display("FAIL ecalu_mask got=%h exp=00020000", ex_busy_mask); else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b0) $display("FAIL ecalu_release got=%b exp=0", stall); else n_pass++;
        tick();
        idle();
        n_total++;
        if (ecall_stall_count !== 4'd1) $display("FAIL ecalu_ecnt got=%0d exp=1", ecall_stall_count); else n_pass++;
        n_total++;
        if (stall_count !== 4'd1) $display("FAIL ecalu_cnt got=%0d exp=1", stall_count); else n_pass++;
    endtask

    task automatic test_ecall_load();
        do_reset();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd17, 1'b1, 1'b1);  // lw x17,0(x2)
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);   // ecall
        n_total++;
        if (stall !== 1'b1) $display("FAIL eclw_stall1 got=%b exp=1", stall); else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b1) $display("FAIL eclw_stall2 got=%b exp=1", stall); else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b0) $display("FAIL eclw_release got=%b exp=0", stall); else n_pass++;
        tick();
        idle();
        n_total++;
        if (stall_count !== 4'd2) $display("FAIL eclw_cnt got=%0d exp=2", stall_count); else n_pass++;
        n_total++;
        if (ecall_stall_count !== 4'd2) $display("FAIL eclw_ecnt got=%0d exp=2", ecall_stall_count); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tick();
        flush = 1'b1;
        drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6,x5,x2
        n_total++;
        if (stall !== 1'b0) $display("FAIL fl_stall got=%b exp=0", stall); else n_pass++;
        tick();
        flush = 1'b0;
        idle();
        n_total++;
        if (ex_busy_mask !== 32'h0000_0020) $display("FAIL fl_mask got=%h exp=00000020", ex_busy_mask); else n_pass++;
        n_total++;
        if (stall_count !== 4'd0) $display("FAIL fl_cnt got=%0d exp=0", stall_count); else n_pass++;
        tick();
        n_total++;
        if (ex_busy_mask !== 32'h0) $display("FAIL fl_mask2 got=%h exp=0", ex_busy_mask); else n_pass++;
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
            tick();
            idle();
            tick();
        end
        n_total++;
        if (stall_count !== 4'd15) $display("FAIL sat_cnt got=%0d exp=15", stall_count); else n_pass++;
        n_total++;
        if (ecall_stall_count !== 4'd0) $display("FAIL sat_ecnt got=%0d exp=0", ecall_stall_count); else n_pass++;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        n_total++;
        if (stall !== 1'b1) $display("FAIL rst_midstall_pre got=%b exp=1", stall); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL rst_midstall_stall got=%b exp=0", stall); else n_pass++;
        n_total++;
        if (stall_count !== 4'd0) $display("FAIL rst_midstall_cnt got=%0d exp=0", stall_count); else n_pass++;
        n_total++;
        if (ex_busy_mask !== 32'h0) $display("FAIL rst_midstall_mask got=%h exp=0", ex_busy_mask); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_x0();
        test_ecall_alu();
        test_ecall_load();
        test_flush();
        test_saturate_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
